// File: rtl/spi_s.sv
// SPI mode-0 receive slave: {dc, byte} into a first-word-fall-through FIFO; readback on spi_miso only with SPI_S_MISO_EN.
// Latency: a byte is visible two sclk cycles after the cycle in which its 8th synchronized sck rise is detected.
// Backpressure: none toward the SPI master; a byte arriving at a full FIFO is dropped and rx_ovf is set.
module spi_s #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       sclk,
  input  logic       resetn,
  input  logic       spi_cs_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  output logic       spi_miso,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       rx_empty,
  input  logic       rx_rd,
  output logic       rx_ovf,
  output logic       frame_err,
  input  logic       err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] PUSH  = 2'd2;

  logic [SYNC_STAGES-1:0] cs_q, sck_q, mosi_q, dc_q;
  logic                   cs_s, sck_s, mosi_s, dc_s;
  logic                   sck_d;
  logic                   sck_rise;

  logic [1:0] state;
  logic [2:0] cnt;
  logic [7:0] shreg;
  logic       dc_lat;

  logic [PW-1:0] wptr, rptr;
  logic [8:0]    mem [0:FIFO_DEPTH-1];
  logic          full, pop, push_req, push_ok, ovf_set, ferr_set;

  // Idle levels: cs deasserted, sck low, so reset never looks like an edge.
  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      cs_q   <= '1;
      sck_q  <= '0;
      mosi_q <= '0;
      dc_q   <= '0;
      sck_d  <= 1'b0;
    end else begin
      cs_q   <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
      sck_q  <= {sck_q[SYNC_STAGES-2:0], spi_sck};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      dc_q   <= {dc_q[SYNC_STAGES-2:0], spi_dc};
      sck_d  <= sck_s;
    end
  end

  assign cs_s     = cs_q[SYNC_STAGES-1];
  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign dc_s     = dc_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;

  assign rx_empty = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop      = rx_rd & ~rx_empty;
  assign push_req = (state == PUSH);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push_ok  = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign ferr_set = (state == SHIFT) & cs_s & (cnt != 3'd0);

  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      shreg  <= 8'h00;
      dc_lat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!cs_s) begin
            state <= SHIFT;
            cnt   <= 3'd0;
          end
        end
        SHIFT: begin
          if (cs_s) begin
            state <= IDLE;
            cnt   <= 3'd0;
          end else if (sck_rise) begin
            shreg <= {shreg[6:0], mosi_s};
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              dc_lat <= dc_s;
              state  <= PUSH;
            end
          end
        end
        PUSH: begin
          cnt   <= 3'd0;
          state <= cs_s ? IDLE : SHIFT;
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      wptr      <= '0;
      rptr      <= '0;
      rx_ovf    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      rx_ovf    <= ovf_set  | (rx_ovf    & ~err_clr);
      frame_err <= ferr_set | (frame_err & ~err_clr);
    end
  end

  always_ff @(posedge sclk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= {dc_lat, shreg};
  end

  // Head is masked while empty so stale storage never shows after reset.
  assign rx_data = rx_empty ? 8'h00 : mem[rptr[AW-1:0]][7:0];
  assign rx_dc   = rx_empty ? 1'b0  : mem[rptr[AW-1:0]][8];

`ifdef SPI_S_MISO_EN
  logic       sck_fall;
  logic [7:0] last_byte;
  logic [7:0] tx_sr;

  assign sck_fall = ~sck_s & sck_d;

  // The fall trailing bit 7 arrives with cnt back at 0; skipping it keeps the freshly loaded MSB.
  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      last_byte <= 8'h00;
      tx_sr     <= 8'h00;
    end else if (state == IDLE && !cs_s) begin
      tx_sr <= last_byte;
    end else if (state == PUSH) begin
      last_byte <= shreg;
      tx_sr     <= shreg;
    end else if (state == SHIFT && !cs_s && sck_fall && cnt != 3'd0) begin
      tx_sr <= {tx_sr[6:0], 1'b0};
    end
  end

  assign spi_miso = tx_sr[7];
`else
  assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_s.sv
// Directed bench for spi_s: SPI master driven at sclk/8, outputs sampled on sclk falling edges.
module tb_spi_s;

  logic       sclk = 1'b0;
  logic       resetn = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_dc = 1'b0;
  logic       rx_rd = 1'b0;
  logic       err_clr = 1'b0;
  logic       spi_miso;
  logic [7:0] rx_data;
  logic       rx_dc;
  logic       rx_empty;
  logic       rx_ovf;
  logic       frame_err;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] miso_cap = 8'h00;
  logic [7:0] miso_exp;

  spi_s #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .sclk      (sclk),
    .resetn    (resetn),
    .spi_cs_n  (spi_cs_n),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_dc    (spi_dc),
    .spi_miso  (spi_miso),
    .rx_data   (rx_data),
    .rx_dc     (rx_dc),
    .rx_empty  (rx_empty),
    .rx_rd     (rx_rd),
    .rx_ovf    (rx_ovf),
    .frame_err (frame_err),
    .err_clr   (err_clr)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic bit_lo(input logic b, input logic d);
    spi_mosi = b;
    spi_dc   = d;
    wait_n(4);
    miso_cap = {miso_cap[6:0], spi_miso};
    spi_sck  = 1'b1;
  endtask

  task automatic bit_hi;
    wait_n(4);
    spi_sck = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input logic d);
    for (int i = 0; i < n; i++) begin
      bit_lo(b[7-i], d);
      bit_hi();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    send_bits(b, 8, d);
    wait_n(8);
  endtask

  task automatic cs_lo;
    spi_cs_n = 1'b0;
    wait_n(6);
  endtask

  task automatic cs_hi;
    wait_n(2);
    spi_cs_n = 1'b1;
    wait_n(6);
  endtask

  task automatic pop;
    rx_rd = 1'b1;
    wait_n(1);
    rx_rd = 1'b0;
    wait_n(1);
  endtask

  task automatic clr;
    err_clr = 1'b1;
    wait_n(1);
    err_clr = 1'b0;
    wait_n(1);
  endtask

  initial begin
    // Reset values
    wait_n(3);
    chk("rst_empty", {8'h0, rx_empty}, 9'h1);
    chk("rst_head", {rx_dc, rx_data}, 9'h000);
    chk("rst_flags", {7'h0, rx_ovf, frame_err}, 9'h0);
    chk("rst_miso", {8'h0, spi_miso}, 9'h0);
    resetn = 1'b1;
    wait_n(3);

    // Single byte 0xA5, dc=1, with push latency
    cs_lo();
    send_bits(8'hA5, 7, 1'b1);
    bit_lo(1'b1, 1'b1);
    wait_n(3);
    chk("lat_still_empty", {8'h0, rx_empty}, 9'h1);
    wait_n(1);
    chk("lat_visible", {8'h0, rx_empty}, 9'h0);
    bit_hi();
    cs_hi();
    chk("a5_head", {rx_dc, rx_data}, 9'h1A5);
    chk("a5_flags", {7'h0, rx_ovf, frame_err}, 9'h0);
    pop();
    chk("a5_drained", {8'h0, rx_empty}, 9'h1);

    // Overflow: five bytes into depth 4
    cs_lo();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), i[0]);
    cs_hi();
    chk("ovf_set", {8'h0, rx_ovf}, 9'h1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovf_head%0d", i), {rx_dc, rx_data}, {i[0], 8'(i)});
      pop();
    end
    chk("ovf_drained", {8'h0, rx_empty}, 9'h1);
    clr();
    chk("ovf_cleared", {8'h0, rx_ovf}, 9'h0);

    // Frame error: 3 bits then cs high, then 0x3C
    cs_lo();
    send_bits(8'hE0, 3, 1'b0);
    cs_hi();
    chk("ferr_set", {8'h0, frame_err}, 9'h1);
    chk("ferr_discard", {8'h0, rx_empty}, 9'h1);
    cs_lo();
    send_byte(8'h3C, 1'b0);
    cs_hi();
    chk("ferr_3c", {rx_dc, rx_data}, 9'h03C);
    pop();
    chk("ferr_only_one", {8'h0, rx_empty}, 9'h1);
    clr();
    chk("ferr_cleared", {8'h0, frame_err}, 9'h0);

    // Full FIFO with pop coinciding with the push of 0x77
    cs_lo();
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b0);
    send_bits(8'h77, 7, 1'b1);
    bit_lo(1'b1, 1'b1);
    wait_n(3);
    rx_rd = 1'b1;
    wait_n(1);
    rx_rd = 1'b0;
    wait_n(1);
    spi_sck = 1'b0;
    wait_n(4);
    cs_hi();
    chk("full_pop_no_ovf", {8'h0, rx_ovf}, 9'h0);
    chk("full_pop_h0", {rx_dc, rx_data}, 9'h011);
    pop();
    chk("full_pop_h1", {rx_dc, rx_data}, 9'h012);
    pop();
    chk("full_pop_h2", {rx_dc, rx_data}, 9'h013);
    pop();
    chk("full_pop_tail", {rx_dc, rx_data}, 9'h177);
    pop();
    chk("full_pop_drained", {8'h0, rx_empty}, 9'h1);

    // Reset after 5 bits of a byte, with one byte already queued
    cs_lo();
    send_byte(8'h42, 1'b1);
    send_bits(8'hFF, 5, 1'b1);
    resetn = 1'b0;
    wait_n(1);
    chk("mrst_empty", {8'h0, rx_empty}, 9'h1);
    chk("mrst_head", {rx_dc, rx_data}, 9'h000);
    chk("mrst_flags", {7'h0, rx_ovf, frame_err}, 9'h0);
    chk("mrst_miso", {8'h0, spi_miso}, 9'h0);
    wait_n(2);
    resetn = 1'b1;
    wait_n(6);
    send_byte(8'h81, 1'b1);
    cs_hi();
    chk("mrst_81", {rx_dc, rx_data}, 9'h181);
    chk("mrst_81_flags", {7'h0, rx_ovf, frame_err}, 9'h0);
    pop();
    chk("mrst_drained", {8'h0, rx_empty}, 9'h1);

    // Readback: 0x5A then 0x00; miso captured across the second byte
    cs_lo();
    send_byte(8'h5A, 1'b1);
    miso_cap = 8'h00;
    send_byte(8'h00, 1'b1);
    cs_hi();
`ifdef SPI_S_MISO_EN
    miso_exp = 8'h5A;
`else
    miso_exp = 8'h00;
`endif
    chk("miso_readback", {1'b0, miso_cap}, {1'b0, miso_exp});
    chk("miso_5a_head", {rx_dc, rx_data}, 9'h15A);
    pop();
    chk("miso_00_head", {rx_dc, rx_data}, 9'h100);
    pop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
